fir_coef_loader: RTL and testbench

- Sequences coefficient loading into the FIR tap shift chain (25-bit cfg data, shift on cfg_ce).
- CPU registers write taps into an internal coefficient buffer, then issue start. The block streams the taps into the chain in the order that makes tap k hold buffer word k.
- It also issues a clear pulse and reports busy, done and error status.
- It runs in the cfg clock domain.

---
 rtl/fir_coef_loader.sv | 147 ++++++++++++++
 tb/tb_fir_coef_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// ============================================================================
// Module      : fir_coef_loader
// Description : Streams a CPU-written coefficient buffer into an FIR tap chain.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_coef_loader #(
  parameter int MAX_LEN   = 64,
  parameter int AW        = 6,
  parameter int CLEAR_LEN = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [24:0]   i_wr_data,
  input  logic          i_start,
  input  logic          i_clear,
  input  logic          i_abort,
  input  logic [31:0]   i_fir_len,
  output logic [24:0]   o_cfg_din,
  output logic          o_cfg_ce,
  output logic          o_cfg_clear,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_wr_rej
);

  localparam int          CW        = (CLEAR_LEN > 1) ? $clog2(CLEAR_LEN) : 1;
  localparam logic [AW:0] c_max_len = (AW+1)'(MAX_LEN);
  localparam logic [AW:0] c_one     = (AW+1)'(1);
  localparam logic [CW-1:0] c_clr_last = CW'(CLEAR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [24:0]     r_mem [MAX_LEN];
  logic [24:0]     r_rd_data;
  logic [AW-1:0]   r_rd_addr;
  logic [AW:0]     r_cnt;
  logic [CW-1:0]   r_clr_cnt;
  logic            r_err;
  logic            r_wr_rej;
  logic            w_len_ok;
  logic            w_go;
  logic            w_addr_ok;
  logic            w_wr_accept;
  logic            w_rd_en;
  logic            w_run;

  assign w_len_ok    = (i_fir_len != 32'd0) && (i_fir_len <= 32'(MAX_LEN));
  assign w_go        = (r_state == S_IDLE) && i_start && w_len_ok;
  assign w_addr_ok   = {1'b0, i_wr_addr} < c_max_len;
  assign w_wr_accept = i_wr_en && (r_state == S_IDLE) && w_addr_ok;
  assign w_run       = (r_state == S_PRIME) || (r_state == S_SHIFT);
  // The final SHIFT cycle skips the read so cfg_din keeps buffer[0] afterwards.
  assign w_rd_en     = (r_state == S_PRIME) || ((r_state == S_SHIFT) && (r_cnt != c_one));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_cfg_ce    = 1'b0;
    o_cfg_clear = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (w_len_ok) w_next = S_PRIME;
        end else if (i_clear) begin
          w_next = S_CLR;
        end
      end
      S_PRIME: begin
        w_next = i_abort ? S_IDLE : S_SHIFT;
      end
      S_SHIFT: begin
        o_cfg_ce = 1'b1;
        if (i_abort)            w_next = S_IDLE;
        else if (r_cnt == c_one) w_next = S_DONE;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      S_CLR: begin
        o_cfg_clear = 1'b1;
        if (r_clr_cnt == c_clr_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_rd_addr <= '0;
      r_cnt     <= '0;
      r_clr_cnt <= '0;
      r_err     <= 1'b0;
      r_wr_rej  <= 1'b0;
    end else begin
      if (w_go) begin
        r_cnt     <= i_fir_len[AW:0];
        r_rd_addr <= i_fir_len[AW-1:0] - 1'b1;
      end else begin
        if (r_state == S_SHIFT) r_cnt <= r_cnt - c_one;
        if (w_rd_en)            r_rd_addr <= r_rd_addr - 1'b1;
      end

      if (w_rd_en) r_rd_data <= r_mem[r_rd_addr];

      if (r_state == S_CLR) r_clr_cnt <= r_clr_cnt + CW'(1);
      else                  r_clr_cnt <= '0;

      if ((r_state == S_IDLE) && i_start) r_err <= !w_len_ok;
      else if (w_run && i_abort)          r_err <= 1'b1;

      r_wr_rej <= i_wr_en && !w_wr_accept;
    end
  end

  assign o_cfg_din = r_rd_data;
  assign o_err     = r_err;
  assign o_wr_rej  = r_wr_rej;

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// ============================================================================
// Module      : tb_fir_coef_loader
// Description : Randomized self-checking bench with a buffer/chain reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_coef_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [5:0]  i_wr_addr = '0;
  logic [24:0] i_wr_data = '0;
  logic        i_start = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_abort = 1'b0;
  logic [31:0] i_fir_len = '0;
  logic [24:0] o_cfg_din;
  logic        o_cfg_ce;
  logic        o_cfg_clear;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_wr_rej;

  int n_vec = 0;
  int n_err = 0;
  logic [24:0] mbuf [64];
  logic [24:0] chain [64];
  int inj_addr = 0;

  fir_coef_loader #(.MAX_LEN(64), .AW(6), .CLEAR_LEN(1)) dut (
    .clk(clk), .reset(reset),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_start(i_start), .i_clear(i_clear), .i_abort(i_abort), .i_fir_len(i_fir_len),
    .o_cfg_din(o_cfg_din), .o_cfg_ce(o_cfg_ce), .o_cfg_clear(o_cfg_clear),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_wr_rej(o_wr_rej)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wr(input int a, input logic [24:0] d);
    i_wr_en = 1'b1; i_wr_addr = 6'(a); i_wr_data = d;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    mbuf[a] = d;
    @(negedge clk);
    check_eq("wr_rej_idle", 32'(o_wr_rej), 0);
    @(posedge clk); #1;
  endtask

  // Cycle 0 carries start; cycle n is checked at its falling edge.
  task automatic run_load(input int len, input int wr_at, input int ab_at, input bit with_clr);
    bit aborted;
    bit e_ce, e_busy, e_done, e_err, e_rej;
    int bad;
    aborted = (ab_at > 0);
    for (int i = 0; i < 64; i++) chain[i] = '0;
    i_fir_len = 32'(len); i_start = 1'b1; i_clear = with_clr;
    @(posedge clk); #1;
    i_start = 1'b0; i_clear = 1'b0;
    for (int n = 1; n <= len + 3; n++) begin
      i_wr_en   = (n == wr_at);
      i_wr_addr = 6'(inj_addr);
      i_wr_data = 25'($urandom);
      i_abort   = (n == ab_at);
      if (n == 2) i_fir_len = $urandom;
      @(negedge clk);
      e_ce   = (n >= 2) && (n <= len + 1) && (!aborted || n <= ab_at);
      e_busy = aborted ? (n <= ab_at) : (n <= len + 2);
      e_done = !aborted && (n == len + 2);
      e_err  = aborted && (n > ab_at);
      e_rej  = (wr_at > 0) && (n == wr_at + 1);
      check_eq("cfg_ce", 32'(o_cfg_ce), 32'(e_ce));
      check_eq("busy", 32'(o_busy), 32'(e_busy));
      check_eq("done", 32'(o_done), 32'(e_done));
      check_eq("err", 32'(o_err), 32'(e_err));
      check_eq("wr_rej", 32'(o_wr_rej), 32'(e_rej));
      check_eq("cfg_clear", 32'(o_cfg_clear), 0);
      if (e_ce) check_eq("cfg_din", 32'(o_cfg_din), 32'(mbuf[len - 1 - (n - 2)]));
      if (e_done) check_eq("din_hold", 32'(o_cfg_din), 32'(mbuf[0]));
      if (o_cfg_ce) begin
        for (int i = 63; i > 0; i--) chain[i] = chain[i-1];
        chain[0] = o_cfg_din;
      end
      @(posedge clk); #1;
      i_wr_en = 1'b0; i_abort = 1'b0;
    end
    if (!aborted) begin
      bad = 0;
      for (int k = 0; k < len; k++) if (chain[k] !== mbuf[k]) bad++;
      check_eq("chain_contents", 32'(bad), 0);
    end
  endtask

  task automatic bad_start(input int len);
    i_fir_len = 32'(len); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_eq("bad_busy", 32'(o_busy), 0);
      check_eq("bad_ce", 32'(o_cfg_ce), 0);
      check_eq("bad_err", 32'(o_err), 1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #3;
    check_eq("rst_din", 32'(o_cfg_din), 0);
    check_eq("rst_ce", 32'(o_cfg_ce), 0);
    check_eq("rst_clear", 32'(o_cfg_clear), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_done", 32'(o_done), 0);
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_wr_rej", 32'(o_wr_rej), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 21; k++) wr(k, 25'(k + 1));
    run_load(21, -1, -1, 1'b0);
    run_load(1, -1, -1, 1'b0);

    for (int k = 0; k < 64; k++) wr(k, 25'($urandom));
    run_load(64, -1, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) wr(int'($urandom_range(0, 63)), 25'($urandom));
      run_load(int'($urandom_range(1, 64)), -1, -1, 1'b0);
    end

    bad_start(0);
    bad_start(65);
    run_load(7, -1, -1, 1'b0);

    inj_addr = 3;
    run_load(21, 5, -1, 1'b0);
    run_load(21, -1, -1, 1'b0);

    run_load(21, -1, 6, 1'b0);
    run_load(21, -1, -1, 1'b1);

    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    @(negedge clk);
    check_eq("clr_pulse", 32'(o_cfg_clear), 1);
    check_eq("clr_busy", 32'(o_busy), 1);
    check_eq("clr_done", 32'(o_done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("clr_end", 32'(o_cfg_clear), 0);
    check_eq("clr_busy_end", 32'(o_busy), 0);
    @(posedge clk); #1;

    i_fir_len = 32'd21; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_ce", 32'(o_cfg_ce), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst_ce", 32'(o_cfg_ce), 0);
    check_eq("mid_rst_busy", 32'(o_busy), 0);
    check_eq("mid_rst_din", 32'(o_cfg_din), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    run_load(21, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
